// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer
//
// Upstream feeder for the FIR MAC controller. Accepts samples over a
// valid/ready handshake into a circular delay line of TAPS entries. For
// every accepted sample it pulses stf_o for one cycle. It then walks the
// taps k = 0..TAPS-1, presenting x[n-k] and k, and advancing one tap per
// lda_i strobe. z_o marks the final tap. New samples are held off until the
// controller reports end-of-filter on eof_i.
//
// Optional feature macro: FIR_SEQ_SKID_EN. When it is defined, a one-entry
// skid register lets the upstream hand over the next sample while a filter
// pass is still in progress.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   smp_i      input sample (DW bits)
//   smp_vld_i  sample valid
//   smp_rdy_o  sample ready (a transfer happens on smp_vld_i & smp_rdy_o)
//   eof_i      end-of-filter from the MAC controller (high = controller idle)
//   lda_i      accumulate strobe; one tap is consumed per high cycle in RUN
//   stf_o      one-cycle start-filter pulse
//   z_o        last-tap flag (k == TAPS-1 while in RUN)
//   tap_idx_o  coefficient address k (AW bits)
//   smp_o      delayed sample x[n-k]
module fir_tap_sequencer #(
    parameter int DW   = 8,
    parameter int TAPS = 8,
    localparam int AW  = $clog2(TAPS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] smp_i,
    input  logic          smp_vld_i,
    output logic          smp_rdy_o,
    input  logic          eof_i,
    input  logic          lda_i,
    output logic          stf_o,
    output logic          z_o,
    output logic [AW-1:0] tap_idx_o,
    output logic [DW-1:0] smp_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [AW-1:0] K_LAST  = AW'(TAPS - 1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t        state_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] k_r;
    logic [AW-1:0] rd_ptr_s;
    logic [DW-1:0] dly_r [TAPS];
    logic          idle_s;
    logic          accept_s;
    logic          start_s;
    logic [DW-1:0] start_dat_s;

`ifdef FIR_SEQ_SKID_EN
    logic          skid_full_r;
    logic [DW-1:0] skid_r;
    logic          skid_fill_s;
`endif

    assign idle_s   = (state_r == ST_IDLE);
    // TAPS is a power of two, so AW-bit wrap gives the modulo-TAPS subtraction.
    assign rd_ptr_s = wr_ptr_r - k_r;

`ifdef FIR_SEQ_SKID_EN
    // An empty skid can always take a sample. When the skid drains into IDLE
    // it is still full in that cycle, so new input is refused then.
    assign smp_rdy_o = ~rst_i & ~skid_full_r;
`else
    assign smp_rdy_o = ~rst_i & idle_s & eof_i;
`endif

    assign accept_s  = smp_vld_i & smp_rdy_o;
    assign stf_o     = (state_r == ST_START);
    assign z_o       = (state_r == ST_RUN) & (k_r == K_LAST);
    assign tap_idx_o = k_r;
    assign smp_o     = dly_r[rd_ptr_s];

    // Decide whether a filter pass starts this cycle and which sample it uses.
    always_comb begin
        start_s     = 1'b0;
        start_dat_s = smp_i;
`ifdef FIR_SEQ_SKID_EN
        skid_fill_s = 1'b0;
        if (idle_s && eof_i && skid_full_r) begin
            start_s     = 1'b1;
            start_dat_s = skid_r;
        end else if (accept_s) begin
            if (idle_s && eof_i) begin
                start_s = 1'b1;
            end else begin
                skid_fill_s = 1'b1;
            end
        end else begin
            start_s = 1'b0;
        end
`else
        if (accept_s) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
`endif
    end

    // Sequencer FSM, tap counter, write pointer and delay line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            wr_ptr_r <= {AW{1'b0}};
            k_r      <= {AW{1'b0}};
            for (int i = 0; i < TAPS; i++) begin
                dly_r[i] <= {DW{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        dly_r[wr_ptr_r] <= start_dat_s;
                        k_r             <= {AW{1'b0}};
                        state_r         <= ST_START;
                    end
                end
                ST_START: begin
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    if (lda_i) begin
                        if (k_r == K_LAST) begin
                            wr_ptr_r <= wr_ptr_r + PTR_ONE;
                            k_r      <= {AW{1'b0}};
                            state_r  <= ST_DRAIN;
                        end else begin
                            k_r <= k_r + PTR_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (eof_i) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FIR_SEQ_SKID_EN
    // One-entry skid buffer that holds a sample accepted while busy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            skid_full_r <= 1'b0;
            skid_r      <= {DW{1'b0}};
        end else if (skid_fill_s) begin
            skid_full_r <= 1'b1;
            skid_r      <= smp_i;
        end else if (start_s) begin
            skid_full_r <= 1'b0;
        end
    end
`endif

endmodule
